// File: rtl/retire_trace_buf.sv
// retire_trace_buf: circular retire trace with overwrite-on-full, drop counting and idle watchdog
module retire_trace_buf #(
  parameter int DEPTH = 16,
  parameter int PC_W = 32,
  parameter int DATA_W = 64,
  parameter int TIMEOUT = 40
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ret_valid,
  input  logic [PC_W-1:0]                ret_pc,
  input  logic [4:0]                     ret_robid,
  input  logic                           ret_dst_vld,
  input  logic [4:0]                     ret_dst_reg,
  input  logic [DATA_W-1:0]              ret_data,
  input  logic                           ret_nuke,
  input  logic                           out_ready,
  input  logic                           freeze_clr,
  output logic                           out_valid,
  output logic [12+PC_W+DATA_W-1:0]      out_rec,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic [15:0]                    overflow_cnt,
  output logic                           hang
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int RW = 12 + PC_W + DATA_W;
  typedef enum logic {RUN, FROZEN} state_t;
  state_t state;
  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [15:0] idle_cnt;
  logic push, pop, full;
  assign full = count == CW'(DEPTH);
  assign out_valid = count != '0;
  assign out_rec = mem[rd_ptr];
  assign push = ret_valid && state == RUN;
  assign pop = out_valid && out_ready;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {ret_nuke, ret_pc, ret_robid, ret_dst_vld, ret_dst_reg, ret_data};
  // a push into a full buffer without a pop evicts the oldest entry
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      overflow_cnt <= '0;
      idle_cnt <= '0;
      hang <= 1'b0;
      state <= RUN;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop || (push && full)) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop && !full) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (freeze_clr) begin
        idle_cnt <= '0;
        overflow_cnt <= '0;
        hang <= 1'b0;
        state <= RUN;
      end else begin
        if (push && !pop && full && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 1'b1;
        if (state == RUN) begin
          idle_cnt <= ret_valid ? '0 : idle_cnt + 1'b1;
          if (!ret_valid && idle_cnt == 16'(TIMEOUT-1)) begin
            state <= FROZEN;
            hang <= 1'b1;
          end
        end
      end
    end
  end
endmodule
